atm_multi_account_ctrl: RTL

//  Parametrised next-generation ATM transaction controller. Serves NUM_ACCTS accounts selected by card id.
//  Per account it keeps: PIN, balance, attempt count, lock flag and daily withdrawal total.

---
 rtl/atm_multi_account_ctrl.sv | 299 +++++++++++++++++++++++++++++
 1 files changed

// File: rtl/atm_multi_account_ctrl.sv
// ---------------------------------------------------------------------------
// atm_multi_account_ctrl
//   Multi-account ATM transaction controller sitting between the card
//   reader/keypad front end and the cash dispenser/display logic.
//   Each account keeps a balance, a wrong-PIN count, a lock flag and a daily
//   withdrawal total. PINs are fixed by the PIN_TABLE parameter.
//   Supports deposit, withdrawal (with daily limit) and balance query, plus
//   an inactivity timeout while waiting for PIN digits or an amount.
//
// Ports
//   clk                  clock, all state changes on posedge
//   rst                  synchronous active-low reset
//   tarjeta_recibida     card present (level)
//   tarjeta_id           account of the inserted card, latched on acceptance
//   tipo_trans           00 deposit, 01 withdrawal, 1x balance query
//   digito_stb/digito    keypad digit strobe and BCD value
//   monto_stb/monto      amount strobe and value
//   nuevo_dia            pulse, clears every daily withdrawal total
//   balance_actualizado  pulse, balance changed or reported on balance_out
//   entregar_dinero      pulse, dispense monto
//   pin_incorrecto       pulse, wrong PIN evaluated
//   advertencia          level, wrong-PIN count reached WARN_TRIES
//   bloqueo              level, session sitting in the locked state
//   fondos_insuficientes pulse, monto larger than balance
//   limite_excedido      pulse, daily withdrawal limit would be exceeded
//   tiempo_agotado       pulse, session aborted by inactivity
//   balance_out          current account balance, valid with balance_actualizado
// ---------------------------------------------------------------------------
module atm_multi_account_ctrl #(
    parameter int unsigned NUM_ACCTS   = 4,
    parameter int unsigned PIN_DIGITS  = 4,
    parameter logic [NUM_ACCTS*4*PIN_DIGITS-1:0] PIN_TABLE = {NUM_ACCTS{16'h4756}},
    parameter int unsigned MAX_TRIES   = 3,
    parameter int unsigned WARN_TRIES  = 2,
    parameter int unsigned AMT_W       = 32,
    parameter int unsigned BAL_W       = 64,
    parameter longint unsigned INIT_BAL = 4500,
    parameter longint unsigned WD_LIMIT = 10000,
    parameter int unsigned TIMEOUT_CYC = 1024,
    localparam int unsigned IDW = (NUM_ACCTS > 1) ? $clog2(NUM_ACCTS) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             tarjeta_recibida,
    input  logic [IDW-1:0]   tarjeta_id,
    input  logic [1:0]       tipo_trans,
    input  logic             digito_stb,
    input  logic [3:0]       digito,
    input  logic             monto_stb,
    input  logic [AMT_W-1:0] monto,
    input  logic             nuevo_dia,
    output logic             balance_actualizado,
    output logic             entregar_dinero,
    output logic             pin_incorrecto,
    output logic             advertencia,
    output logic             bloqueo,
    output logic             fondos_insuficientes,
    output logic             limite_excedido,
    output logic             tiempo_agotado,
    output logic [BAL_W-1:0] balance_out
);

    localparam int unsigned PW  = 4 * PIN_DIGITS;
    localparam int unsigned CW  = ((AMT_W > BAL_W) ? AMT_W : BAL_W) + 1;
    localparam int unsigned TW  = $clog2(MAX_TRIES + 1);
    localparam int unsigned DCW = $clog2(PIN_DIGITS + 1);
    localparam int unsigned ICW = $clog2(TIMEOUT_CYC + 1);

    typedef enum logic [2:0] {
        ESPERA,
        PIN,
        EVAL,
        TRANS,
        BLOQUEO
    } state_t;

    state_t           state_q, state_d;
    logic [IDW-1:0]   id_q;
    logic [1:0]       tipo_q;
    logic [PW-1:0]    pin_q;
    logic [DCW-1:0]   dcnt_q;
    logic [ICW-1:0]   idle_q;

    logic [BAL_W-1:0] bal_q   [NUM_ACCTS];
    logic [BAL_W-1:0] daily_q [NUM_ACCTS];
    logic [TW-1:0]    tries_q [NUM_ACCTS];
    logic             lock_q  [NUM_ACCTS];

    // control decisions from the next-state logic
    logic accept, shift_en, tipo_ld, pin_ok, pin_bad, dep_en, wd_en, timeout;

    // next values of the registered outputs
    logic             bal_act_d, entregar_d, pin_inc_d, adv_d, bloqueo_d;
    logic             fondos_d, limite_d, tiempo_d;
    logic [BAL_W-1:0] balance_out_d;

    // current-account views and widened arithmetic
    logic [BAL_W-1:0] cur_bal, cur_daily, dep_sat, wd_bal;
    logic [TW-1:0]    cur_tries, tries_inc;
    logic [CW-1:0]    bal_w, amt_w, daily_w, dep_sum, wd_total;
    logic             pin_match, idle_hit;

    always_comb begin
        cur_bal   = bal_q[id_q];
        cur_daily = daily_q[id_q];
        cur_tries = tries_q[id_q];
        tries_inc = cur_tries + TW'(1);
        pin_match = (pin_q == PIN_TABLE[int'(id_q)*PW +: PW]);
        idle_hit  = (idle_q == ICW'(TIMEOUT_CYC - 1));

        bal_w     = CW'(cur_bal);
        amt_w     = CW'(monto);
        daily_w   = CW'(cur_daily);
        dep_sum   = bal_w + amt_w;
        wd_total  = daily_w + amt_w;
        // any carry above BAL_W means the deposit overflowed: saturate
        dep_sat   = (|dep_sum[CW-1:BAL_W]) ? '1 : dep_sum[BAL_W-1:0];
        wd_bal    = cur_bal - BAL_W'(monto);
    end

    always_comb begin
        state_d       = state_q;
        accept        = 1'b0;
        shift_en      = 1'b0;
        tipo_ld       = 1'b0;
        pin_ok        = 1'b0;
        pin_bad       = 1'b0;
        dep_en        = 1'b0;
        wd_en         = 1'b0;
        timeout       = 1'b0;
        bal_act_d     = 1'b0;
        entregar_d    = 1'b0;
        pin_inc_d     = 1'b0;
        fondos_d      = 1'b0;
        limite_d      = 1'b0;
        tiempo_d      = 1'b0;
        adv_d         = advertencia;
        balance_out_d = balance_out;

        case (state_q)
            ESPERA: begin
                if (tarjeta_recibida) begin
                    accept  = 1'b1;
                    state_d = lock_q[tarjeta_id] ? BLOQUEO : PIN;
                end
            end
            PIN: begin
                if (!tarjeta_recibida) begin
                    state_d = ESPERA;
                end else if (digito_stb) begin
                    shift_en = 1'b1;
                    if (dcnt_q == DCW'(PIN_DIGITS - 1)) state_d = EVAL;
                end else if (!monto_stb && idle_hit) begin
                    timeout = 1'b1;
                end
            end
            EVAL: begin
                if (!tarjeta_recibida) begin
                    state_d = ESPERA;
                end else if (pin_match) begin
                    pin_ok  = 1'b1;
                    tipo_ld = 1'b1;
                    adv_d   = 1'b0;
                    if (tipo_trans[1]) begin
                        bal_act_d     = 1'b1;
                        balance_out_d = cur_bal;
                        state_d       = ESPERA;
                    end else begin
                        state_d = TRANS;
                    end
                end else begin
                    pin_bad   = 1'b1;
                    pin_inc_d = 1'b1;
                    adv_d     = (tries_inc >= TW'(WARN_TRIES));
                    state_d   = (tries_inc == TW'(MAX_TRIES)) ? BLOQUEO : PIN;
                end
            end
            TRANS: begin
                if (!tarjeta_recibida) begin
                    state_d = ESPERA;
                end else if (monto_stb) begin
                    state_d = ESPERA;
                    if (tipo_q == 2'b00) begin
                        dep_en        = 1'b1;
                        bal_act_d     = 1'b1;
                        balance_out_d = dep_sat;
                    end else if (tipo_q == 2'b01) begin
                        if (amt_w > bal_w) begin
                            fondos_d = 1'b1;
                        end else if (wd_total > CW'(WD_LIMIT)) begin
                            limite_d = 1'b1;
                        end else begin
                            wd_en         = 1'b1;
                            entregar_d    = 1'b1;
                            bal_act_d     = 1'b1;
                            balance_out_d = wd_bal;
                        end
                    end else begin
                        bal_act_d     = 1'b1;
                        balance_out_d = cur_bal;
                    end
                end else if (!digito_stb && idle_hit) begin
                    timeout = 1'b1;
                end
            end
            BLOQUEO: begin
                if (!tarjeta_recibida) state_d = ESPERA;
            end
            default: state_d = ESPERA;
        endcase

        if (timeout) begin
            tiempo_d = 1'b1;
            state_d  = ESPERA;
        end

        if (state_d != PIN && state_d != EVAL) adv_d = 1'b0;
        bloqueo_d = (state_d == BLOQUEO);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q              <= ESPERA;
            balance_actualizado  <= 1'b0;
            entregar_dinero      <= 1'b0;
            pin_incorrecto       <= 1'b0;
            advertencia          <= 1'b0;
            bloqueo              <= 1'b0;
            fondos_insuficientes <= 1'b0;
            limite_excedido      <= 1'b0;
            tiempo_agotado       <= 1'b0;
            balance_out          <= '0;
        end else begin
            state_q              <= state_d;
            balance_actualizado  <= bal_act_d;
            entregar_dinero      <= entregar_d;
            pin_incorrecto       <= pin_inc_d;
            advertencia          <= adv_d;
            bloqueo              <= bloqueo_d;
            fondos_insuficientes <= fondos_d;
            limite_excedido      <= limite_d;
            tiempo_agotado       <= tiempo_d;
            balance_out          <= balance_out_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            id_q   <= '0;
            tipo_q <= '0;
            pin_q  <= '0;
            dcnt_q <= '0;
            idle_q <= '0;
        end else begin
            if (accept)  id_q   <= tarjeta_id;
            if (tipo_ld) tipo_q <= tipo_trans;
            if (shift_en) pin_q <= {pin_q[PW-5:0], digito};

            // digit count only lives in PIN, so entering PIN always starts at 0
            if (state_q != PIN)  dcnt_q <= '0;
            else if (shift_en)   dcnt_q <= dcnt_q + DCW'(1);

            if (state_d != state_q || digito_stb || monto_stb ||
                (state_q != PIN && state_q != TRANS))
                idle_q <= '0;
            else
                idle_q <= idle_q + ICW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int unsigned k = 0; k < NUM_ACCTS; k++) begin
                bal_q[k]   <= BAL_W'(INIT_BAL);
                daily_q[k] <= '0;
                tries_q[k] <= '0;
                lock_q[k]  <= 1'b0;
            end
        end else begin
            for (int unsigned k = 0; k < NUM_ACCTS; k++) begin
                if (nuevo_dia) daily_q[k] <= '0;
                if (id_q == IDW'(k)) begin
                    if (pin_ok) tries_q[k] <= '0;
                    if (pin_bad) begin
                        tries_q[k] <= tries_inc;
                        if (tries_inc == TW'(MAX_TRIES)) lock_q[k] <= 1'b1;
                    end
                    if (dep_en) bal_q[k] <= dep_sat;
                    if (wd_en) begin
                        bal_q[k] <= wd_bal;
                        // a same-cycle new day leaves only this withdrawal on the total
                        daily_q[k] <= nuevo_dia ? BAL_W'(monto) : wd_total[BAL_W-1:0];
                    end
                end
            end
        end
    end

endmodule
